// File: rtl/fwd_scoreboard_if.sv
// Signal bundle between the pipeline and fwd_scoreboard: EX producer, WB load data,
// ID operand requests, and the forwarded operands and stall status.
interface fwd_scoreboard_if #(
   parameter int unsigned W32  = 32,
   parameter int unsigned W128 = 128,
   parameter int unsigned AW   = 5,
   parameter int unsigned NSRC = 2
);
   logic                   ex_valid;
   logic [AW-1:0]          ex_dst;
   logic                   ex_wide;
   logic                   ex_load;
   logic [W32-1:0]         ex_res_32;
   logic [W128-1:0]        ex_res_128;
   logic [W32-1:0]         mem_rd_32;
   logic [W128-1:0]        mem_rd_128;
   logic [NSRC*AW-1:0]     src_addr;
   logic [NSRC-1:0]        src_wide;
   logic [NSRC*W32-1:0]    rf_32;
   logic [NSRC*W128-1:0]   rf_128;
   logic [NSRC*W32-1:0]    op_32;
   logic [NSRC*W128-1:0]   op_128;
   logic [2*NSRC-1:0]      fwd_sel;
   logic                   stall;
   logic [15:0]            stall_cnt;

   modport master (
      output ex_valid, ex_dst, ex_wide, ex_load, ex_res_32, ex_res_128,
             mem_rd_32, mem_rd_128, src_addr, src_wide, rf_32, rf_128,
      input  op_32, op_128, fwd_sel, stall, stall_cnt
   );

   modport slave (
      input  ex_valid, ex_dst, ex_wide, ex_load, ex_res_32, ex_res_128,
             mem_rd_32, mem_rd_128, src_addr, src_wide, rf_32, rf_128,
      output op_32, op_128, fwd_sel, stall, stall_cnt
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand forwarding scoreboard: tracks the M and WB producers, selects each ID operand
// from M, WB, the register file or the zero register, and raises stall on hazards.
module fwd_scoreboard #(
   parameter int unsigned W32  = 32,
   parameter int unsigned W128 = 128,
   parameter int unsigned AW   = 5,
   parameter int unsigned NSRC = 2
) (
   input logic             clk,
   input logic             rst,
   fwd_scoreboard_if.slave bus
);

   typedef struct packed {
      logic            valid;
      logic [AW-1:0]   dst;
      logic            wide;
      logic            load;
      logic [W32-1:0]  res_32;
      logic [W128-1:0] res_128;
   } stage_t;

   localparam logic [15:0] CntMax  = 16'hFFFF;
   localparam logic [1:0]  SelRf   = 2'b00;
   localparam logic [1:0]  SelM    = 2'b01;
   localparam logic [1:0]  SelWb   = 2'b10;
   localparam logic [1:0]  SelZero = 2'b11;

   stage_t                r_m;
   stage_t                r_wb;
   logic [15:0]           r_stall_cnt;

   logic [W32-1:0]        w_wb_32;
   logic [W128-1:0]       w_wb_128;
   logic [NSRC-1:0]       w_hazard;
   logic                  w_stall;
   logic [NSRC*W32-1:0]   w_op_32;
   logic [NSRC*W128-1:0]  w_op_128;
   logic [2*NSRC-1:0]     w_sel;

   // A load in WB forwards the memory read data, never its (meaningless) ALU result.
   assign w_wb_32  = r_wb.load ? bus.mem_rd_32  : r_wb.res_32;
   assign w_wb_128 = r_wb.load ? bus.mem_rd_128 : r_wb.res_128;

   for (genvar g = 0; g < NSRC; g++) begin : g_ch
      logic [AW-1:0]   w_addr;
      logic            w_zero;
      logic            w_m_dst;
      logic            w_m_hit;
      logic            w_wb_dst;
      logic            w_wb_hit;
      logic            w_hz;
      logic [1:0]      w_ch_sel;
      logic [W32-1:0]  w_ch_32;
      logic [W128-1:0] w_ch_128;

      assign w_addr   = bus.src_addr[g*AW +: AW];
      assign w_zero   = (w_addr == '0);
      assign w_m_dst  = r_m.valid & (r_m.dst == w_addr);
      assign w_m_hit  = w_m_dst & (r_m.wide == bus.src_wide[g]);
      assign w_wb_dst = r_wb.valid & (r_wb.dst == w_addr);
      assign w_wb_hit = w_wb_dst & (r_wb.wide == bus.src_wide[g]);

      // The youngest writer of the register decides; a width mismatch there cannot forward.
      always_comb begin
         w_ch_sel = SelRf;
         w_hz     = 1'b0;
         if (w_zero) begin
            w_ch_sel = SelZero;
         end else if (w_m_hit) begin
            w_ch_sel = SelM;
            w_hz     = r_m.load;
         end else if (w_m_dst) begin
            w_hz     = 1'b1;
         end else if (w_wb_hit) begin
            w_ch_sel = SelWb;
         end else if (w_wb_dst) begin
            w_hz     = 1'b1;
         end
      end

      always_comb begin
         w_ch_32  = '0;
         w_ch_128 = '0;
         unique case (w_ch_sel)
            SelRf: begin
               w_ch_32  = bus.rf_32[g*W32 +: W32];
               w_ch_128 = bus.rf_128[g*W128 +: W128];
            end
            SelM: begin
               w_ch_32  = r_m.res_32;
               w_ch_128 = r_m.res_128;
            end
            SelWb: begin
               w_ch_32  = w_wb_32;
               w_ch_128 = w_wb_128;
            end
            SelZero: begin
               w_ch_32  = '0;
               w_ch_128 = '0;
            end
         endcase
      end

      assign w_hazard[g]            = w_hz;
      assign w_sel[2*g +: 2]        = w_ch_sel;
      assign w_op_32[g*W32 +: W32]  = w_ch_32;
      assign w_op_128[g*W128 +: W128] = w_ch_128;
   end

   assign w_stall       = |w_hazard;
   assign bus.stall     = w_stall;
   assign bus.stall_cnt = r_stall_cnt;
   assign bus.fwd_sel   = w_sel;
   assign bus.op_32     = w_op_32;
   assign bus.op_128    = w_op_128;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_m         <= '0;
         r_wb        <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_wb          <= r_m;
         // A stalled EX instruction is held upstream, so M takes a bubble.
         r_m.valid     <= bus.ex_valid & ~w_stall;
         r_m.dst       <= bus.ex_dst;
         r_m.wide      <= bus.ex_wide;
         r_m.load      <= bus.ex_load;
         r_m.res_32    <= bus.ex_res_32;
         r_m.res_128   <= bus.ex_res_128;
         if (w_stall && (r_stall_cnt != CntMax)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed hazard scenarios plus random traffic, checked against
// a model that forwards from the youngest in-flight writer of each register.
module tb_fwd_scoreboard;
   localparam int unsigned W32  = 32;
   localparam int unsigned W128 = 128;
   localparam int unsigned AW   = 5;
   localparam int unsigned NSRC = 2;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   fwd_scoreboard_if #(.W32(W32), .W128(W128), .AW(AW), .NSRC(NSRC)) bus ();

   fwd_scoreboard #(.W32(W32), .W128(W128), .AW(AW), .NSRC(NSRC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit            valid;
      bit [AW-1:0]   dst;
      bit            wide;
      bit            load;
      bit [W32-1:0]  r32;
      bit [W128-1:0] r128;
   } prod_t;

   // In-flight producers, youngest first; at most two are still visible to ID.
   prod_t       hist[$];
   logic [15:0] m_cnt;

   function automatic logic [127:0] r128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   function automatic void model_reset();
      prod_t e;
      e = '{valid: 1'b0, dst: '0, wide: 1'b0, load: 1'b0, r32: '0, r128: '0};
      hist.delete();
      hist.push_back(e);
      hist.push_back(e);
      m_cnt = 16'd0;
   endfunction

   function automatic void predict(input int ch, output bit hz, output logic [1:0] sel,
                                   output logic [W32-1:0] e32, output logic [W128-1:0] e128);
      logic [AW-1:0] addr;
      logic          wd;
      addr = bus.src_addr[ch*AW +: AW];
      wd   = bus.src_wide[ch];
      hz   = 1'b0;
      sel  = 2'b00;
      e32  = bus.rf_32[ch*W32 +: W32];
      e128 = bus.rf_128[ch*W128 +: W128];
      if (addr == 0) begin
         sel  = 2'b11;
         e32  = '0;
         e128 = '0;
         return;
      end
      for (int a = 0; a < hist.size(); a++) begin
         if (hist[a].valid && hist[a].dst == addr) begin
            if (hist[a].wide != wd || (a == 0 && hist[a].load)) begin
               hz = 1'b1;
            end else begin
               sel  = (a == 0) ? 2'b01 : 2'b10;
               e32  = hist[a].load ? bus.mem_rd_32  : hist[a].r32;
               e128 = hist[a].load ? bus.mem_rd_128 : hist[a].r128;
            end
            return;
         end
      end
   endfunction

   function automatic bit model_stall();
      bit               hz;
      bit               st;
      logic [1:0]       sel;
      logic [W32-1:0]   e32;
      logic [W128-1:0]  e128;
      st = 1'b0;
      for (int ch = 0; ch < NSRC; ch++) begin
         predict(ch, hz, sel, e32, e128);
         st = st | hz;
      end
      return st;
   endfunction

   function automatic void commit();
      prod_t e;
      bit    st;
      st = model_stall();
      if (st) m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
      e.valid = bus.ex_valid && !st;
      e.dst   = bus.ex_dst;
      e.wide  = bus.ex_wide;
      e.load  = bus.ex_load;
      e.r32   = bus.ex_res_32;
      e.r128  = bus.ex_res_128;
      hist.push_front(e);
      hist = hist[0:1];
   endfunction

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_model(input string tag);
      bit              hz;
      bit              st;
      logic [1:0]      sel;
      logic [W32-1:0]  e32;
      logic [W128-1:0] e128;
      st = 1'b0;
      for (int ch = 0; ch < NSRC; ch++) begin
         predict(ch, hz, sel, e32, e128);
         st = st | hz;
         if (!hz) begin
            chk({tag, "_sel"}, 128'(bus.fwd_sel[ch*2 +: 2]), 128'(sel));
            chk({tag, "_op32"}, 128'(bus.op_32[ch*W32 +: W32]), 128'(e32));
            chk({tag, "_op128"}, bus.op_128[ch*W128 +: W128], e128);
         end
      end
      chk({tag, "_stall"}, 128'(bus.stall), 128'(st));
      chk({tag, "_cnt"}, 128'(bus.stall_cnt), 128'(m_cnt));
   endtask

   task automatic step(input string tag);
      #1;
      check_model(tag);
   endtask

   task automatic tick();
      @(posedge clk);
      commit();
      @(negedge clk);
   endtask

   task automatic set_ex(input bit v, input int d, input bit w, input bit l,
                         input logic [W32-1:0] r32);
      bus.ex_valid   = v;
      bus.ex_dst     = AW'(d);
      bus.ex_wide    = w;
      bus.ex_load    = l;
      bus.ex_res_32  = r32;
      bus.ex_res_128 = r128();
   endtask

   task automatic set_src(input int ch, input int a, input bit w);
      bus.src_addr[ch*AW +: AW] = AW'(a);
      bus.src_wide[ch]          = w;
   endtask

   task automatic rand_data();
      bus.rf_32      = {$urandom(), $urandom()};
      bus.rf_128     = {r128(), r128()};
      bus.mem_rd_32  = $urandom();
      bus.mem_rd_128 = r128();
   endtask

   initial begin
      rst = 1'b1;
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 3, 1'b0);
      set_src(1, 0, 1'b0);
      rand_data();
      model_reset();

      // Reset: pass-through from the register file, zero register on channel 1.
      @(negedge clk);
      step("rst_hold");
      chk("rst_stall", 128'(bus.stall), 128'(0));
      chk("rst_cnt", 128'(bus.stall_cnt), 128'(0));
      chk("rst_sel0", 128'(bus.fwd_sel[1:0]), 128'(2'b00));
      chk("rst_sel1", 128'(bus.fwd_sel[3:2]), 128'(2'b11));
      chk("rst_op0", 128'(bus.op_32[31:0]), 128'(bus.rf_32[31:0]));
      chk("rst_op1", 128'(bus.op_32[63:32]), 128'(0));
      #1 rst = 1'b0;
      tick();

      // Forward a fresh 32-bit result from M.
      set_ex(1'b1, 3, 1'b0, 1'b0, 32'h1234);
      set_src(0, 9, 1'b0);
      rand_data();
      step("r3_issue");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 3, 1'b0);
      rand_data();
      step("r3_fwd");
      chk("r3_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b01));
      chk("r3_op32", 128'(bus.op_32[31:0]), 128'(32'h1234));
      chk("r3_stall", 128'(bus.stall), 128'(0));
      tick();

      // Same register in WB and M: the younger M value wins.
      set_ex(1'b1, 3, 1'b0, 1'b0, 32'hA);
      set_src(0, 9, 1'b0);
      step("dup_a");
      tick();
      set_ex(1'b1, 3, 1'b0, 1'b0, 32'hB);
      step("dup_b");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 3, 1'b0);
      rand_data();
      step("dup_rd");
      chk("dup_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b01));
      chk("dup_op32", 128'(bus.op_32[31:0]), 128'(32'hB));
      tick();

      // Load-use: one stall cycle, then the load data comes from WB.
      set_ex(1'b1, 5, 1'b0, 1'b1, 32'hDEAD);
      set_src(0, 9, 1'b0);
      step("ld_issue");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 5, 1'b0);
      step("ld_use");
      chk("ld_stall", 128'(bus.stall), 128'(1));
      tick();
      rand_data();
      step("ld_fwd");
      chk("ld_stall_off", 128'(bus.stall), 128'(0));
      chk("ld_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b10));
      chk("ld_op32", 128'(bus.op_32[31:0]), 128'(bus.mem_rd_32));
      chk("ld_cnt", 128'(bus.stall_cnt), 128'(1));
      tick();

      // Width mismatch: stall while the 128-bit producer is in M and in WB.
      set_ex(1'b1, 7, 1'b1, 1'b0, 32'h77);
      set_src(0, 9, 1'b0);
      step("w_issue");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 7, 1'b0);
      step("w_m");
      chk("w_stall_m", 128'(bus.stall), 128'(1));
      tick();
      step("w_wb");
      chk("w_stall_wb", 128'(bus.stall), 128'(1));
      tick();
      rand_data();
      step("w_done");
      chk("w_stall_done", 128'(bus.stall), 128'(0));
      chk("w_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b00));
      chk("w_op32", 128'(bus.op_32[31:0]), 128'(bus.rf_32[31:0]));
      tick();

      // Writes to r0 are never visible.
      set_ex(1'b1, 0, 1'b0, 1'b0, 32'hFFFF);
      set_src(0, 9, 1'b0);
      step("r0_issue");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 0, 1'b0);
      step("r0_rd");
      chk("r0_op32", 128'(bus.op_32[31:0]), 128'(0));
      chk("r0_op128", bus.op_128[127:0], 128'(0));
      chk("r0_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b11));
      chk("r0_stall", 128'(bus.stall), 128'(0));
      tick();

      // Reset mid-stall drops the pending load and clears the count before the next edge.
      set_ex(1'b1, 5, 1'b0, 1'b1, 32'h55);
      set_src(0, 9, 1'b0);
      step("rs_issue");
      tick();
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      set_src(0, 5, 1'b0);
      step("rs_pre");
      chk("rs_pre_stall", 128'(bus.stall), 128'(1));
      #1 rst = 1'b1;
      #1 model_reset();
      check_model("rs_mid");
      chk("rs_stall", 128'(bus.stall), 128'(0));
      chk("rs_cnt", 128'(bus.stall_cnt), 128'(0));
      chk("rs_sel", 128'(bus.fwd_sel[1:0]), 128'(2'b00));
      #1 rst = 1'b0;
      tick();

      // Saturation: preload the counter near the top, then keep stalling.
      set_src(0, 9, 1'b0);
      set_src(1, 0, 1'b0);
      force dut.r_stall_cnt = 16'hFFF0;
      m_cnt = 16'hFFF0;
      step("sat_force");
      tick();
      release dut.r_stall_cnt;
      step("sat_start");
      for (int i = 0; i < 40; i++) begin
         set_ex(1'b1, 7, 1'b1, 1'b0, $urandom());
         set_src(0, 7, 1'b0);
         rand_data();
         step("sat");
         tick();
      end
      set_ex(1'b0, 0, 1'b0, 1'b0, '0);
      step("sat_end");
      chk("sat_hold", 128'(bus.stall_cnt), 128'(16'hFFFF));
      tick();

      // Random traffic over a small register window, with occasional async resets.
      for (int it = 0; it < 3000; it++) begin
         set_ex(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0), $urandom());
         for (int ch = 0; ch < NSRC; ch++) begin
            set_src(ch, int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
         end
         rand_data();
         step("rnd");
         if ($urandom_range(0, 149) == 0) begin
            #1 rst = 1'b1;
            #1 model_reset();
            check_model("rnd_rst");
            #1 rst = 1'b0;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
